// File: rtl/adder_share_arbiter_if.sv
// Request/response bus between the requesters and adder_share_arbiter.
// master: requester/consumer side. slave: arbiter side.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*4-1:0] req_a;
    logic [NUM_REQ*4-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [4:0]           rsp_sum;
    logic                 rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external 4-bit adder among NUM_REQ requesters.
// Flow per transaction: IDLE (grant + latch operands) -> ADD (adder settles,
// sum captured) -> RESP (hold result until consumer accepts) -> IDLE.
// Optional feature: define ADDER_ARB_OVF_CNT_EN to add ovf_count_o, a saturating
// 8-bit count of accepted results whose carry bit is set.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus,
    output logic [3:0]           add_a_o,
    output logic [3:0]           add_b_o,
    input  logic [4:0]           add_s_i,
    output logic                 busy_o
`ifdef ADDER_ARB_OVF_CNT_EN
    ,
    output logic [7:0]           ovf_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [3:0]         add_a_q, add_a_d;
    logic [3:0]         add_b_q, add_b_d;
    logic [4:0]         rsp_sum_q, rsp_sum_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic [3:0]         sel_a, sel_b;
    logic [NUM_REQ-1:0] req_ready_c;

`ifdef ADDER_ARB_OVF_CNT_EN
    logic [7:0]         ovf_q, ovf_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    // Pointer advance with explicit wrap so non-power-of-two NUM_REQ works.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return id + ID_W'(1);
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Operand mux and one-hot ready; ready is forced low while reset is held.
    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        req_ready_c = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_a          = bus.req_a[4*k +: 4];
                sel_b          = bus.req_b[4*k +: 4];
                req_ready_c[k] = rst_n && grant_found && (state_q == S_IDLE);
            end
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_id_d    = rsp_id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_valid_d = rsp_valid_q;
`ifdef ADDER_ARB_OVF_CNT_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    add_a_d  = sel_a;
                    add_b_d  = sel_b;
                    rsp_id_d = grant_idx;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                rsp_sum_d   = add_s_i;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = next_ptr(rsp_id_q);
                    state_d     = S_IDLE;
`ifdef ADDER_ARB_OVF_CNT_EN
                    if (rsp_sum_q[4]) begin
                        ovf_d = sat_inc8(ovf_q);
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, latched operands and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            rsp_id_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_id_q    <= rsp_id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef ADDER_ARB_OVF_CNT_EN
    // Saturating carry-out counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count_o = ovf_q;
`endif

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign add_a_o       = add_a_q;
    assign add_b_o       = add_b_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter: directed and randomized transactions
// against a transaction-level reference model (round-robin scan + plain addition).
module tb_adder_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] add_a, add_b;
    logic [4:0] add_s;
    logic       busy;
`ifdef ADDER_ARB_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    int total   = 0;
    int bad     = 0;
    int exp_ptr = 0;
    int exp_ovf = 0;
    int cyc     = 0;

    adder_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    adder_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .add_a_o (add_a),
        .add_b_o (add_b),
        .add_s_i (add_s),
        .busy_o  (busy)
`ifdef ADDER_ARB_OVF_CNT_EN
        ,
        .ovf_count_o (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External 4-bit adder with carry out.
    assign add_s = 5'(add_a) + 5'(add_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] rv, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rv[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        bus.req_a[4*i +: 4] = a;
        bus.req_b[4*i +: 4] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    // One full transaction from IDLE; entered on a falling edge, returns on a falling edge in IDLE.
    task automatic txn(input int bp, output int gid);
        int         g;
        logic [3:0] ea, eb;
        logic [4:0] es;
        g   = model_grant(bus.req_valid, exp_ptr);
        gid = g;
        #1;
        if (g < 0) begin
            check("no_grant_ready", 32'(bus.req_ready), 32'd0);
            return;
        end
        ea = bus.req_a[4*g +: 4];
        eb = bus.req_b[4*g +: 4];
        es = 5'(ea) + 5'(eb);
        check("grant", 32'(bus.req_ready), 32'(1) << g);
        check("busy_idle", 32'(busy), 32'd0);
        bus.rsp_ready = (bp == 0);
        @(negedge clk);
        check("add_a", 32'(add_a), 32'(ea));
        check("add_b", 32'(add_b), 32'(eb));
        check("busy_add", 32'(busy), 32'd1);
        check("ready_add", 32'(bus.req_ready), 32'd0);
        check("valid_add", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_id", 32'(bus.rsp_id), 32'(g));
        check("rsp_sum", 32'(bus.rsp_sum), 32'(es));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_id", 32'(bus.rsp_id), 32'(g));
            check("bp_sum", 32'(bus.rsp_sum), 32'(es));
            check("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        exp_ptr = (g + 1) % NUM_REQ;
        if (es[4] && exp_ovf < 255) exp_ovf++;
        check("valid_done", 32'(bus.rsp_valid), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
`ifdef ADDER_ARB_OVF_CNT_EN
        check("ovf_count", 32'(ovf_count), 32'(exp_ovf));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
        check({tag, "_sum"}, 32'(bus.rsp_sum), 32'd0);
        check({tag, "_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_add_b"}, 32'(add_b), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
`ifdef ADDER_ARB_OVF_CNT_EN
        check({tag, "_ovf"}, 32'(ovf_count), 32'd0);
`endif
    endtask

    initial begin
        int         g;
        int         r;
        int         t0;
        logic [3:0] ba [3];
        logic [3:0] bb [3];
        logic [4:0] bs [3];
        ba = '{4'd15, 4'd0, 4'd8};
        bb = '{4'd15, 4'd0, 4'd8};
        bs = '{5'd30, 5'd0, 5'd16};

        // Power-on reset with a request pending
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no request
        #1;
        check("idle_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // All four requesting continuously: order 0,1,2,3,0 at 3 cycles each
        rand_ops();
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_order", 32'(bus.req_ready), 32'(1) << (i % NUM_REQ));
            txn(0, g);
        end
        check("txn_cycles", 32'(cyc - t0), 32'd15);

        // Single request from requester 2: 9 + 8
        bus.req_valid = 4'b0100;
        set_op(2, 4'd9, 4'd8);
        txn(0, g);
        check("t2_id", 32'(bus.rsp_id), 32'd2);
        check("t2_sum", 32'(bus.rsp_sum), 32'd17);

        // Backpressure for 5 cycles with another requester waiting
        rand_ops();
        bus.req_valid = 4'b0011;
        txn(5, g);

        // Operand boundaries
        for (int i = 0; i < 3; i++) begin
            r = $urandom_range(0, NUM_REQ - 1);
            bus.req_valid = 4'(1 << r);
            set_op(r, ba[i], bb[i]);
            txn(0, g);
            check("bnd_sum", 32'(bus.rsp_sum), 32'(bs[i]));
        end

        // Randomized traffic
        repeat (40) begin
            rand_ops();
            bus.req_valid = 4'($urandom_range(1, 15));
            txn($urandom_range(0, 2), g);
        end

        // Reset while a result is pending; pointer must restart at 0
        bus.req_valid = 4'b0001;
        txn(0, g);
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b0;
        #1;
        check("pre_rst_grant", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_ptr = 0;
        exp_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        txn(0, g);

`ifdef ADDER_ARB_OVF_CNT_EN
        // Carry counter saturation, then a non-carry add leaves it unchanged
        repeat (300) begin
            r = $urandom_range(0, NUM_REQ - 1);
            bus.req_valid = 4'(1 << r);
            set_op(r, 4'($urandom_range(8, 15)), 4'($urandom_range(8, 15)));
            txn(0, g);
        end
        check("ovf_sat", 32'(ovf_count), 32'd255);
        bus.req_valid = 4'b0001;
        set_op(0, 4'd3, 4'd4);
        txn(0, g);
        check("ovf_hold", 32'(ovf_count), 32'd255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
